// File: rtl/mb_scan_pkg.sv
// Shared constants, FSM state type and coordinate packing for the macroblock scan generator.
package mb_scan_pkg;

  localparam int BLK = 4;

  typedef enum logic {IDLE, SCAN} state_t;

  function automatic logic [31:0] pack_mb(input logic [15:0] row, input logic [15:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/mb_scan_gen_if.sv
// Block-coordinate handshake between the scan generator (master) and its consumer (slave).
interface mb_scan_gen_if;
  logic        mb_valid;
  logic        mb_ready;
  logic [31:0] mbnumber;
  logic        mb_first;
  logic        mb_last;

  modport master (output mb_valid, mbnumber, mb_first, mb_last, input mb_ready);
  modport slave  (input mb_valid, mbnumber, mb_first, mb_last, output mb_ready);
endinterface

// File: rtl/mb_scan_gen_blk_counter.sv
// Pixel-coordinate counter stepping by BLK from 0 to LIMIT-BLK, then wrapping to 0.
module blk_counter
  import mb_scan_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value,
  output logic        wrap
);

  localparam logic [15:0] LAST = 16'(LIMIT - BLK);

  // wrap flags the final position, so the caller can carry on the same edge.
  assign wrap = (value == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr)      value <= '0;
    else if (inc) value <= wrap ? 16'd0 : value + 16'(BLK);
  end

endmodule

// File: rtl/mb_scan_gen.sv
// Raster-order 4x4 macroblock coordinate generator with a valid/ready output handshake.
module mb_scan_gen
  import mb_scan_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  mb_scan_gen_if.master mb,
  output logic          busy,
  output logic          done
);

  if ((WIDTH % BLK) != 0 || WIDTH < BLK || WIDTH > 65535) begin : g_bad_width
    $error("mb_scan_gen: WIDTH must be a non-zero multiple of BLK and <= 65535");
  end
  if ((LENGTH % BLK) != 0 || LENGTH < BLK || LENGTH > 65535) begin : g_bad_length
    $error("mb_scan_gen: LENGTH must be a non-zero multiple of BLK and <= 65535");
  end

  state_t      state;
  logic        valid_q;
  logic [15:0] col, row;
  logic        col_wrap, row_wrap;
  logic        xfer, last_blk;

  assign xfer     = valid_q && mb.mb_ready && enable;
  assign last_blk = col_wrap && row_wrap;

  // Both counters wrap to 0 on the final transfer, so IDLE always sees {0,0}.
  blk_counter #(.LIMIT(WIDTH)) u_col (
    .clk(clk), .clr(reset), .inc(xfer), .value(col), .wrap(col_wrap)
  );

  blk_counter #(.LIMIT(LENGTH)) u_row (
    .clk(clk), .clr(reset), .inc(xfer && col_wrap), .value(row), .wrap(row_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // done is a strict one-cycle pulse, so it clears even while enable is low.
      done <= 1'b0;
      if (enable) begin
        case (state)
          IDLE: if (start) begin
            state   <= SCAN;
            valid_q <= 1'b1;
            busy    <= 1'b1;
          end
          SCAN: if (xfer && last_blk) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mb.mb_valid = valid_q;
  assign mb.mbnumber = pack_mb(row, col);
  assign mb.mb_first = valid_q && (row == 16'd0) && (col == 16'd0);
  assign mb.mb_last  = valid_q && last_blk;

endmodule
